// File: rtl/irq_controller_if.sv
// Request/acknowledge handshake between the interrupt controller and the CPU
// pipeline.
//   int_en  : global interrupt enable driven by the CPU
//   int_ack : single-cycle pulse, the pipeline has taken int_id
//   int_ret : single-cycle pulse, the pipeline executed an interrupt return
//   int_req : an eligible interrupt is being offered
//   int_id  : index of the offered source, valid only while int_req=1
// The master modport is the controller side; the slave modport is the pipeline side.
interface irq_controller_if #(
  parameter int IDW = 2
);
  logic           int_en;
  logic           int_ack;
  logic           int_ret;
  logic           int_req;
  logic [IDW-1:0] int_id;

  modport master (
    input  int_en,
    input  int_ack,
    input  int_ret,
    output int_req,
    output int_id
  );

  modport slave (
    output int_en,
    output int_ack,
    output int_ret,
    input  int_req,
    input  int_id
  );
endinterface

// File: rtl/irq_controller.sv
// Interrupt controller with nested in-service tracking.
// The controller captures rising edges on irq_i as pending requests. It offers
// the highest-index pending source to the pipeline when that source outranks
// everything already in service. It tracks nested in-service levels until the
// pipeline returns. It also flags requests that re-fire while still pending.
// Ports:
//   clk       : single clock, rising edge
//   rst       : synchronous active-high reset
//   irq_i     : raw request lines, one request per 0->1 transition
//   bus       : handshake interface (master side), see irq_controller_if
//   irw_o     : in-service bitmap, including preempted sources
//   pending_o : latched requests that have not yet been acknowledged
//   lost_o    : sticky, set when a source re-fires while already pending
module irq_controller #(
  parameter int N   = 3,
  parameter int IDW = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N-1:0]         irq_i,
  irq_controller_if.master     bus,
  output logic [N-1:0]         irw_o,
  output logic [N-1:0]         pending_o,
  output logic [N-1:0]         lost_o
);

  logic [N-1:0]   irq_q;
  logic [N-1:0]   pending_q;
  logic [N-1:0]   pending_d;
  logic [N-1:0]   irw_q;
  logic [N-1:0]   irw_d;
  logic [N-1:0]   lost_q;
  logic [N-1:0]   lost_d;

  logic [N-1:0]   rise_s;
  logic [N-1:0]   ack_mask_s;
  logic [N-1:0]   ret_mask_s;
  logic [IDW-1:0] cand_s;
  logic [IDW-1:0] level_s;
  logic           pend_any_s;
  logic           irw_any_s;
  logic           req_s;

  // Index of the highest set bit; 0 when no bit is set, so callers qualify with |v.
  function automatic logic [IDW-1:0] top_idx(input logic [N-1:0] v);
    logic [IDW-1:0] r;
    r = '0;
    for (int i = 0; i < N; i++) begin
      if (v[i]) begin
        r = IDW'(i);
      end
    end
    return r;
  endfunction

  // One-hot mask of N bits with the bit at position idx set.
  function automatic logic [N-1:0] onehot(input logic [IDW-1:0] idx);
    logic [N-1:0] m;
    m = '0;
    for (int i = 0; i < N; i++) begin
      if (IDW'(i) == idx) begin
        m[i] = 1'b1;
      end
    end
    return m;
  endfunction

  // Arbitration and next-state computation from the registered state.
  always_comb begin
    rise_s     = irq_i & ~irq_q;
    pend_any_s = |pending_q;
    irw_any_s  = |irw_q;
    cand_s     = top_idx(pending_q);
    level_s    = top_idx(irw_q);

    // An empty in-service map stands for level -1, so any pending source outranks it.
    req_s = bus.int_en & pend_any_s & (~irw_any_s | (cand_s > level_s));

    if (bus.int_ack && req_s) begin
      ack_mask_s = onehot(cand_s);
    end else begin
      ack_mask_s = '0;
    end

    // A return always retires the innermost, which is the highest-priority, service level.
    if (bus.int_ret && irw_any_s) begin
      ret_mask_s = onehot(level_s);
    end else begin
      ret_mask_s = '0;
    end

    // A rise on the source being acknowledged re-arms it: set wins over clear.
    pending_d = (pending_q & ~ack_mask_s) | rise_s;
    lost_d    = lost_q | (rise_s & pending_q & ~ack_mask_s);
    irw_d     = (irw_q & ~ret_mask_s) | ack_mask_s;
  end

  // The offer depends only on registered state and int_en.
  assign bus.int_req = req_s;
  assign bus.int_id  = req_s ? cand_s : '0;

  // State registers. Reset overrides every other input, including an ack or a return.
  always_ff @(posedge clk) begin
    if (rst) begin
      irq_q     <= '0;
      pending_q <= '0;
      irw_q     <= '0;
      lost_q    <= '0;
    end else begin
      irq_q     <= irq_i;
      pending_q <= pending_d;
      irw_q     <= irw_d;
      lost_q    <= lost_d;
    end
  end

  assign irw_o     = irw_q;
  assign pending_o = pending_q;
  assign lost_o    = lost_q;

endmodule

// File: tb/tb_irq_controller.sv
// Self-checking bench for irq_controller (N=3). A reference model keeps pending
// and lost flags as bit arrays and the in-service levels as an explicit stack.
// A compare process checks every output against the model on each falling edge.
// Directed scenarios add literal expectations, followed by randomized traffic.
module tb_irq_controller;
  localparam int N   = 3;
  localparam int IDW = 2;

  logic         clk = 1'b0;
  logic         rst;
  logic [N-1:0] irq;
  logic [N-1:0] irw;
  logic [N-1:0] pend;
  logic [N-1:0] lost;

  irq_controller_if #(.IDW(IDW)) bus_if ();

  irq_controller #(.N(N), .IDW(IDW)) dut (
    .clk       (clk),
    .rst       (rst),
    .irq_i     (irq),
    .bus       (bus_if),
    .irw_o     (irw),
    .pending_o (pend),
    .lost_o    (lost)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_on  = 1'b0;

  // Reference model state.
  bit m_pend [N];
  bit m_lost [N];
  bit m_prev [N];
  int m_stk  [N];
  int m_sp = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end else begin
      n_pass++;
    end
  endtask

  function automatic int m_level();
    return (m_sp == 0) ? -1 : m_stk[m_sp-1];
  endfunction

  function automatic int m_cand();
    int c = -1;
    for (int i = 0; i < N; i++) if (m_pend[i]) c = i;
    return c;
  endfunction

  function automatic bit m_req(input bit en);
    int c = m_cand();
    return en && (c >= 0) && (c > m_level());
  endfunction

  function automatic int m_id(input bit en);
    return m_req(en) ? m_cand() : 0;
  endfunction

  function automatic logic [31:0] m_irw_bits();
    logic [31:0] v = '0;
    for (int j = 0; j < m_sp; j++) v[m_stk[j]] = 1'b1;
    return v;
  endfunction

  function automatic logic [31:0] pack_bits(input bit a [N]);
    logic [31:0] v = '0;
    for (int i = 0; i < N; i++) v[i] = a[i];
    return v;
  endfunction

  // Reference model update on each rising edge.
  always @(posedge clk) begin : model
    bit np [N];
    bit nl [N];
    bit nv [N];
    int ns [N];
    int nsp;
    bit req;
    bit ack;
    bit rise;
    int id;
    if (rst) begin
      for (int i = 0; i < N; i++) begin
        np[i] = 1'b0; nl[i] = 1'b0; nv[i] = 1'b0; ns[i] = 0;
      end
      nsp = 0;
    end else begin
      req = m_req(bus_if.int_en);
      id  = m_id(bus_if.int_en);
      ack = bus_if.int_ack && req;
      ns  = m_stk;
      nsp = m_sp;
      if (bus_if.int_ret && nsp > 0) nsp--;
      if (ack) begin
        ns[nsp] = id;
        nsp++;
      end
      for (int i = 0; i < N; i++) begin
        rise  = irq[i] && !m_prev[i];
        nl[i] = m_lost[i] || (rise && m_pend[i] && !(ack && id == i));
        np[i] = (m_pend[i] && !(ack && id == i)) || rise;
        nv[i] = irq[i];
      end
    end
    m_pend <= np;
    m_lost <= nl;
    m_prev <= nv;
    m_stk  <= ns;
    m_sp   <= nsp;
  end

  // Compare every DUT output with the model once per cycle.
  always @(negedge clk) begin
    if (chk_on) begin
      chk("int_req", 32'(bus_if.int_req), 32'(m_req(bus_if.int_en)));
      chk("int_id",  32'(bus_if.int_id),  32'(m_id(bus_if.int_en)));
      chk("pending", 32'(pend), pack_bits(m_pend));
      chk("irw",     32'(irw),  m_irw_bits());
      chk("lost",    32'(lost), pack_bits(m_lost));
    end
  end

  // Apply one cycle of inputs after the rising edge, then return at the falling edge.
  task automatic go(input logic r, input logic [N-1:0] i, input logic e, input logic a,
                    input logic t);
    @(posedge clk);
    #2;
    rst = r; irq = i; bus_if.int_en = e; bus_if.int_ack = a; bus_if.int_ret = t;
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; irq = 3'b111;
    bus_if.int_en = 1'b0; bus_if.int_ack = 1'b0; bus_if.int_ret = 1'b0;

    // Reset hold with all lines high
    go(1'b1, 3'b111, 1'b1, 1'b0, 1'b0);
    chk_on = 1'b1;
    go(1'b1, 3'b111, 1'b1, 1'b0, 1'b0);
    chk("rst_req", 32'(bus_if.int_req), 32'd0);
    chk("rst_irw", 32'(irw), 32'd0);
    chk("rst_pend", 32'(pend), 32'd0);
    go(1'b0, 3'b111, 1'b1, 1'b0, 1'b0);
    go(1'b0, 3'b111, 1'b1, 1'b0, 1'b0);
    chk("rel_pend", 32'(pend), 32'h7);
    chk("rel_id", 32'(bus_if.int_id), 32'd2);
    go(1'b1, 3'b000, 1'b0, 1'b0, 1'b0);
    go(1'b0, 3'b000, 1'b1, 1'b0, 1'b0);

    // Single service
    go(1'b0, 3'b001, 1'b1, 1'b0, 1'b0);
    go(1'b0, 3'b000, 1'b1, 1'b1, 1'b0);
    chk("s_req", 32'(bus_if.int_req), 32'd1);
    chk("s_id", 32'(bus_if.int_id), 32'd0);
    go(1'b0, 3'b000, 1'b1, 1'b0, 1'b0);
    chk("s_irw", 32'(irw), 32'h1);
    chk("s_pend", 32'(pend), 32'h0);
    chk("s_req0", 32'(bus_if.int_req), 32'd0);
    go(1'b0, 3'b000, 1'b1, 1'b0, 1'b1);
    go(1'b0, 3'b000, 1'b1, 1'b0, 1'b0);
    chk("s_ret", 32'(irw), 32'h0);

    // Nesting three levels deep
    go(1'b0, 3'b001, 1'b1, 1'b0, 1'b0);
    go(1'b0, 3'b000, 1'b1, 1'b1, 1'b0);
    go(1'b0, 3'b010, 1'b1, 1'b0, 1'b0);
    chk("n_irw1", 32'(irw), 32'h1);
    go(1'b0, 3'b000, 1'b1, 1'b1, 1'b0);
    chk("n_id1", 32'(bus_if.int_id), 32'd1);
    go(1'b0, 3'b100, 1'b1, 1'b0, 1'b0);
    chk("n_irw3", 32'(irw), 32'h3);
    go(1'b0, 3'b000, 1'b1, 1'b1, 1'b0);
    chk("n_id2", 32'(bus_if.int_id), 32'd2);
    go(1'b0, 3'b000, 1'b1, 1'b0, 1'b1);
    chk("n_irw7", 32'(irw), 32'h7);
    go(1'b0, 3'b000, 1'b1, 1'b0, 1'b1);
    chk("n_ret1", 32'(irw), 32'h3);
    go(1'b0, 3'b000, 1'b1, 1'b0, 1'b1);
    chk("n_ret2", 32'(irw), 32'h1);
    go(1'b0, 3'b000, 1'b1, 1'b0, 1'b0);
    chk("n_ret3", 32'(irw), 32'h0);

    // Lower priority blocked by an in-service source
    go(1'b0, 3'b100, 1'b1, 1'b0, 1'b0);
    go(1'b0, 3'b000, 1'b1, 1'b1, 1'b0);
    go(1'b0, 3'b010, 1'b1, 1'b0, 1'b0);
    chk("b_irw", 32'(irw), 32'h4);
    go(1'b0, 3'b000, 1'b1, 1'b0, 1'b0);
    chk("b_pend", 32'(pend), 32'h2);
    chk("b_req0", 32'(bus_if.int_req), 32'd0);
    go(1'b0, 3'b000, 1'b1, 1'b0, 1'b1);
    go(1'b0, 3'b000, 1'b1, 1'b0, 1'b0);
    chk("b_req1", 32'(bus_if.int_req), 32'd1);
    chk("b_id1", 32'(bus_if.int_id), 32'd1);
    go(1'b0, 3'b000, 1'b1, 1'b1, 1'b0);
    go(1'b0, 3'b000, 1'b1, 1'b0, 1'b1);
    go(1'b0, 3'b000, 1'b1, 1'b0, 1'b0);

    // Rise on the same edge as the ack of that source
    go(1'b0, 3'b100, 1'b1, 1'b0, 1'b0);
    go(1'b0, 3'b000, 1'b1, 1'b0, 1'b0);
    go(1'b0, 3'b100, 1'b1, 1'b1, 1'b0);
    go(1'b0, 3'b000, 1'b1, 1'b0, 1'b0);
    chk("c1_pend", 32'(pend), 32'h4);
    chk("c1_lost", 32'(lost), 32'h0);
    chk("c1_irw", 32'(irw), 32'h4);
    go(1'b0, 3'b000, 1'b1, 1'b0, 1'b1);
    go(1'b0, 3'b000, 1'b1, 1'b1, 1'b0);
    go(1'b0, 3'b000, 1'b1, 1'b0, 1'b1);
    go(1'b0, 3'b000, 1'b1, 1'b0, 1'b0);

    // Re-fire while pending, then enable in the same cycle
    go(1'b0, 3'b010, 1'b0, 1'b0, 1'b0);
    go(1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
    go(1'b0, 3'b010, 1'b0, 1'b0, 1'b0);
    go(1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
    chk("c2_lost", 32'(lost), 32'h2);
    chk("c2_req0", 32'(bus_if.int_req), 32'd0);
    go(1'b0, 3'b000, 1'b1, 1'b1, 1'b0);
    chk("en_req", 32'(bus_if.int_req), 32'd1);
    go(1'b0, 3'b000, 1'b1, 1'b0, 1'b1);
    go(1'b0, 3'b000, 1'b1, 1'b0, 1'b0);

    // Ack and return on the same edge
    go(1'b0, 3'b001, 1'b1, 1'b0, 1'b0);
    go(1'b0, 3'b000, 1'b1, 1'b1, 1'b0);
    go(1'b0, 3'b100, 1'b1, 1'b0, 1'b0);
    go(1'b0, 3'b000, 1'b1, 1'b1, 1'b1);
    chk("c3_id", 32'(bus_if.int_id), 32'd2);
    go(1'b0, 3'b000, 1'b1, 1'b0, 1'b0);
    chk("c3_irw", 32'(irw), 32'h4);
    go(1'b0, 3'b000, 1'b1, 1'b0, 1'b1);
    go(1'b0, 3'b000, 1'b1, 1'b0, 1'b0);

    // Enable gating and stray pulses
    go(1'b0, 3'b001, 1'b0, 1'b0, 1'b0);
    go(1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
    chk("dis_req", 32'(bus_if.int_req), 32'd0);
    go(1'b0, 3'b000, 1'b1, 1'b0, 1'b0);
    chk("ena_req", 32'(bus_if.int_req), 32'd1);
    go(1'b0, 3'b000, 1'b0, 1'b1, 1'b1);
    go(1'b0, 3'b000, 1'b0, 1'b0, 1'b0);
    chk("stray_pend", 32'(pend), 32'h1);
    chk("stray_irw", 32'(irw), 32'h0);
    chk("stray_lost", 32'(lost), 32'h2);

    // Randomized traffic
    for (int k = 0; k < 1500; k++) begin
      logic [N-1:0] flip;
      flip = N'($urandom_range(0, 7)) & N'($urandom_range(0, 7));
      go(($urandom_range(0, 149) == 0), irq ^ flip, ($urandom_range(0, 7) != 0),
         ($urandom_range(0, 2) == 0), ($urandom_range(0, 4) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
